// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - Moore sequencer that loads an 8-bit shift register and issues eight divided shift strobes.
// Also holds the 8-bit right-shift register (serial out from bit 0) that the sequencer drives.
module shift_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             C,
  input  logic             Reset,
  input  logic             Req,
  input  logic             Abort,
  input  logic [DIV_W-1:0] Div,
  output logic             SLOAD,
  output logic             Shift,
  output logic             Ack,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       BitCnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;

  always_ff @(posedge C or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Abort wins over every transition and also suppresses the BitCnt increment.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    if (Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Req) begin
            state_d  = S_LOAD;
            div_d    = Div;
            bitcnt_d = '0;
          end
        end
        S_LOAD: begin
          state_d = S_WAIT;
          cnt_d   = div_q;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_SHIFT;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        S_SHIFT: begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = div_q;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign SLOAD  = (state_q == S_LOAD);
  assign Ack    = (state_q == S_LOAD);
  assign Shift  = (state_q == S_SHIFT);
  assign Done   = (state_q == S_DONE);
  assign Busy   = (state_q != S_IDLE);
  assign BitCnt = bitcnt_q;

endmodule

module shift_reg8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] d_i,
  input  logic       si_i,
  output logic       so_o,
  output logic [7:0] po_o
);

  logic [7:0] data_q, data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end else if (shift_i) begin
      data_d = {si_i, data_q[7:1]};
    end
  end

  assign so_o = data_q[0];
  assign po_o = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - Randomized scoreboard bench for shift_sequencer and its shift register.
module tb_shift_sequencer;

  typedef struct packed {
    logic       sload;
    logic       shift;
    logic       ack;
    logic       busy;
    logic       done;
    logic [3:0] bitcnt;
  } vec_t;

  logic       C;
  logic       Reset;
  logic       Req;
  logic       Abort;
  logic [7:0] Div;
  logic       SLOAD, Shift, Ack, Busy, Done;
  logic [3:0] BitCnt;
  logic       sr_so;
  logic [7:0] sr_po;

  int compared   = 0;
  int mismatched = 0;

  vec_t exp_q[$];
  vec_t pend[$];
  vec_t cur;

  shift_sequencer #(.DIV_W(8)) dut (
    .C(C), .Reset(Reset), .Req(Req), .Abort(Abort), .Div(Div),
    .SLOAD(SLOAD), .Shift(Shift), .Ack(Ack), .Busy(Busy), .Done(Done), .BitCnt(BitCnt)
  );

  shift_reg8 u_sr (
    .clk_i(C), .rst_i(Reset), .load_i(SLOAD), .shift_i(Shift),
    .d_i(8'hA5), .si_i(1'b0), .so_o(sr_so), .po_o(sr_po)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  function automatic vec_t mk(input logic sl, input logic sh, input logic ak,
                              input logic bz, input logic dn, input logic [3:0] bc);
    vec_t v;
    v.sload = sl; v.shift = sh; v.ack = ak; v.busy = bz; v.done = dn; v.bitcnt = bc;
    return v;
  endfunction

  // Whole operation timeline: load, then per bit (d+1) idle cycles and one shift, then done.
  task automatic build(input logic [7:0] d);
    pend.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0));
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w <= int'(d); w++) pend.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(b)));
      pend.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(b)));
    end
    pend.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8));
  endtask

  task automatic step(input logic r, input logic a, input logic [7:0] d);
    vec_t nxt;
    @(negedge C);
    Req = r; Abort = a; Div = d;
    if (cur.busy) begin
      if (a) begin
        pend.delete();
        nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur.bitcnt);
      end else if (pend.size() > 0) begin
        nxt = pend.pop_front();
      end else begin
        nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur.bitcnt);
      end
    end else if (r) begin
      build(d);
      nxt = pend.pop_front();
    end else begin
      nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur.bitcnt);
    end
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  task automatic pulse_reset();
    vec_t z;
    @(negedge C);
    Req = 1'b0; Abort = 1'b0;
    #1 Reset = 1'b1;
    #1;
    compared++;
    if ({SLOAD, Shift, Ack, Busy, Done, BitCnt} !== 9'd0 || sr_po !== 8'd0) begin
      mismatched++;
      $display("FAIL async_reset: got=%b po=%h required all zero", {SLOAD, Shift, Ack, Busy, Done, BitCnt}, sr_po);
    end
    #1 Reset = 1'b0;
    pend.delete();
    z = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cur = z;
    exp_q.push_back(z);
  endtask

  task automatic idle_steps(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, d);
  endtask

  initial begin : monitor
    vec_t       e, got;
    int         sh_n;
    logic       prev_shift;
    logic [7:0] tmp;
    sh_n = 0;
    prev_shift = 1'b0;
    forever begin
      @(posedge C);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {SLOAD, Shift, Ack, Busy, Done, BitCnt};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t got sload,shift,ack,busy,done,bitcnt=%b required=%b", $time, got, e);
        end
        if (prev_shift && sh_n < 8) begin
          sh_n++;
          tmp = 8'hA5 >> sh_n;
          compared++;
          if (sr_so !== tmp[0]) begin
            mismatched++;
            $display("FAIL serial_out t=%0t after shift %0d got=%b required=%b", $time, sh_n, sr_so, tmp[0]);
          end
        end
        if (got.done) begin
          compared++;
          if (sr_po !== 8'h00) begin
            mismatched++;
            $display("FAIL po_at_done t=%0t got=%h required=00", $time, sr_po);
          end
        end
        if (got.sload) sh_n = 0;
        prev_shift = got.shift;
      end
    end
  end

  initial begin : stimulus
    logic       r, a;
    logic [7:0] d;
    Reset = 1'b1; Req = 1'b0; Abort = 1'b0; Div = 8'd0;
    cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #3;
    compared++;
    if ({SLOAD, Shift, Ack, Busy, Done, BitCnt} !== 9'd0) begin
      mismatched++;
      $display("FAIL reset_state: got=%b required=000000000", {SLOAD, Shift, Ack, Busy, Done, BitCnt});
    end
    @(negedge C);
    Reset = 1'b0;

    step(1'b1, 1'b0, 8'd0);
    idle_steps(20, 8'd0);

    step(1'b1, 1'b0, 8'd3);
    idle_steps(9, 8'd3);
    idle_steps(40, 8'd0);

    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'd0);
    idle_steps(20, 8'd0);

    step(1'b1, 1'b0, 8'd0);
    idle_steps(7, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    idle_steps(12, 8'd0);

    step(1'b0, 1'b1, 8'd2);
    step(1'b1, 1'b1, 8'd2);
    idle_steps(40, 8'd2);

    step(1'b1, 1'b0, 8'd1);
    idle_steps(7, 8'd1);
    pulse_reset();
    step(1'b1, 1'b0, 8'd0);
    idle_steps(20, 8'd0);

    step(1'b1, 1'b0, 8'hFF);
    idle_steps(2060, 8'd0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) d = 8'($urandom);
      else d = 8'($urandom_range(0, 5));
      step(r, a, d);
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge C);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, the width of the per-bit divider input.
REQ-002 The block SHALL have port C, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Req, input, 1 bit: request to load and serialise one 8-bit word.
REQ-005 The block SHALL have port Abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-006 The block SHALL have port Div, input, DIV_W bits: idle cycles inserted before each shift, minus one.
REQ-007 The block SHALL have port SLOAD, output, 1 bit: parallel-load strobe to the 8-bit shift register.
REQ-008 The block SHALL have port Shift, output, 1 bit: shift-enable strobe to the shift register.
REQ-009 The block SHALL have port Ack, output, 1 bit: request-accepted pulse.
REQ-010 The block SHALL have port Busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port Done, output, 1 bit: operation-complete pulse.
REQ-012 The block SHALL have port BitCnt, output, 4 bits: number of shifts issued in the current operation, 0..8.

Function
REQ-013 The block SHALL implement a Moore FSM with states IDLE, LOAD, WAIT, SHIFT and DONE; all outputs SHALL decode from registered state only.
REQ-014 In IDLE with Req=1 at a rising edge of C, the block SHALL go to LOAD, latch Div into an internal register, and clear BitCnt.
REQ-015 In IDLE with Req=0, the block SHALL stay in IDLE.
REQ-016 In LOAD, SLOAD=1 and Ack=1 for exactly one cycle; next state SHALL be WAIT, with the down-counter set to the latched Div.
REQ-017 In WAIT, the counter SHALL decrement each cycle; when it is 0 at an edge, the next state SHALL be SHIFT (so WAIT lasts latched Div+1 cycles).
REQ-018 In SHIFT, Shift=1 for one cycle and BitCnt SHALL increment at the end of that cycle.
REQ-019 On leaving SHIFT, the next state SHALL be DONE if BitCnt was 7; otherwise it SHALL be WAIT with the counter reloaded from the latched Div.
REQ-020 In DONE, Done=1 for one cycle, BitCnt SHALL hold 8, and the next state SHALL be IDLE.
REQ-021 Busy SHALL be 1 in every state except IDLE; for latched Div=N, Busy SHALL stay high for exactly 8N+18 consecutive cycles.
REQ-022 SLOAD and Shift SHALL never be 1 in the same cycle; exactly one SLOAD and exactly eight Shift pulses SHALL occur per completed operation.
REQ-023 Req SHALL be ignored outside IDLE; a Req held high continuously SHALL be accepted again on the first IDLE cycle, giving exactly one IDLE cycle between operations.
REQ-024 Changes on Div after acceptance SHALL NOT affect the operation in progress.
REQ-025 Div=0 SHALL give one WAIT cycle per bit; Div = all-ones SHALL give 2^DIV_W WAIT cycles per bit, with no wrap or overflow of the counter.
REQ-026 Abort=1 in any non-IDLE state SHALL force IDLE at the next edge without Done; BitCnt SHALL retain its value and no further SLOAD or Shift SHALL be issued.
REQ-027 Abort SHALL take priority over Req and over all state transitions; Abort in IDLE SHALL have no effect.

Reset
REQ-028 Reset=1 SHALL immediately, independent of C, force IDLE, SLOAD=0, Shift=0, Ack=0, Busy=0, Done=0, BitCnt=0, and clear the counter and the latched Div.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no Done pulse.
REQ-030 After Reset deasserts, the first Req SHALL be accepted at the next rising edge of C.

Verification
REQ-031 Div=0, Req high for edge 0 only -> SLOAD/Ack at cycle 1; Shift at cycles 3,5,7,9,11,13,15,17; Done at 18; Busy high for cycles 1-18; BitCnt=8 at cycle 18.
REQ-032 Div=3, single Req -> Shift at cycles 6,11,...,41 (period 5); Done at 42; Busy high for 42 cycles; Div changed to 0 at cycle 10 has no effect.
REQ-033 Req held high, Div=0 -> second SLOAD at cycle 20; Busy low for cycle 19 only.
REQ-034 Abort at cycle 8, Div=0 -> IDLE at cycle 9; BitCnt=3; no Done; no further Shift.
REQ-035 Reset pulse mid-WAIT between C edges -> all outputs go to 0 immediately; the next Req after deassertion gives a full 18-cycle operation.
REQ-036 Integration with the 8-bit shift register, D=0xA5 loaded on SLOAD, SI=0 -> SO after each of the 8 Shift pulses reads 0,1,0,0,1,0,1,0 and PO=0x00 at Done.
